jelly_wishbone_to_axi4l: RTL and testbench
==========================================

JELLY_WISHBONE_TO_AXI4L -- requirements
Module: jelly_wishbone_to_axi4l

Interface
REQ-001 SHALL have parameter AXI4L_ADDR_WIDTH, default 29, AXI4-Lite byte address width.
REQ-002 SHALL have parameter AXI4L_DATA_SIZE, default 2, log2 of the data bytes (0:8bit, 1:16bit, 2:32bit, 3:64bit).
REQ-003 SHALL derive local parameters:
- AXI4L_DATA_WIDTH = 8<<AXI4L_DATA_SIZE
- AXI4L_STRB_WIDTH = 1<<AXI4L_DATA_SIZE
- WB_ADR_WIDTH = AXI4L_ADDR_WIDTH-AXI4L_DATA_SIZE
- WB_DAT_WIDTH = AXI4L_DATA_WIDTH
- WB_SEL_WIDTH = AXI4L_STRB_WIDTH
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have the following ports:
- aclk  in  1  sole clock
- aresetn  in  1  asynchronous active-low reset
- s_wb_adr_i  in  WB_ADR_WIDTH  word address
- s_wb_dat_i  in  WB_DAT_WIDTH  write data
- s_wb_dat_o  out  WB_DAT_WIDTH  read data
- s_wb_we_i  in  1  write enable
- s_wb_sel_i  in  WB_SEL_WIDTH  byte select
- s_wb_stb_i  in  1  strobe
- s_wb_ack_o  out  1  acknowledge
- s_wb_err_o  out  1  error, coincident with ack
- m_axi4l_awaddr / awprot[2:0] / awvalid  out;  m_axi4l_awready  in
- m_axi4l_wdata / wstrb / wvalid  out;  m_axi4l_wready  in
- m_axi4l_bresp[1:0] / bvalid  in;  m_axi4l_bready  out
- m_axi4l_araddr / arprot[2:0] / arvalid  out;  m_axi4l_arready  in
- m_axi4l_rdata / rresp[1:0] / rvalid  in;  m_axi4l_rready  out

Function
REQ-006 SHALL implement a Wishbone classic slave to AXI4-Lite master bridge with one transaction outstanding at a time.
REQ-007 SHALL implement the FSM states IDLE, WADDR, WRESP, RADDR, RDATA and ACK.
REQ-008 In IDLE with s_wb_stb_i=1 sampled, SHALL go to WADDR if s_wb_we_i=1, otherwise to RADDR.
REQ-009 On that transition SHALL register the following from the Wishbone inputs:
- awaddr/araddr = {s_wb_adr_i, AXI4L_DATA_SIZE zero bits}
- wdata = s_wb_dat_i
- wstrb = s_wb_sel_i
REQ-010 SHALL drive awprot and arprot as 3'b000 at all times.
REQ-011 In WADDR SHALL assert awvalid and wvalid together, then handle each handshake independently:
- drop awvalid the cycle after awready is sampled;
- drop wvalid the cycle after wready is sampled;
- leave WADDR when both handshakes are done, in either order or in the same cycle.
REQ-012 While any valid is asserted and its ready is low, SHALL hold that valid and its payload stable.
REQ-013 In WRESP SHALL assert bready=1, and on bvalid go to ACK, capturing err = (bresp != 2'b00).
REQ-014 SHALL never assert bready outside WRESP.
REQ-015 In RADDR SHALL assert arvalid until arready is sampled, then go to RDATA.
REQ-016 In RDATA SHALL assert rready=1, and on rvalid go to ACK, capturing s_wb_dat_o = rdata and err = (rresp != 2'b00).
REQ-017 In ACK SHALL assert s_wb_ack_o=1 for exactly one cycle, with s_wb_err_o = captured err, then return to IDLE.
REQ-018 SHALL drive s_wb_ack_o and s_wb_err_o low in every state other than ACK.
REQ-019 Timing: s_wb_ack_o SHALL be registered, and IDLE SHALL NOT sample s_wb_stb_i in the ACK cycle. A strobe held high after ack therefore starts the next transaction in the following IDLE cycle.
REQ-020 Minimum latency with all readies and responses immediate:
- write: stb sampled at edge 0; awvalid/wvalid at cycles 1..1; bready at cycle 2; ack at cycle 3;
- read: same latency, arvalid at cycle 1, rready at cycle 2, ack at cycle 3.
REQ-021 SHALL hold s_wb_dat_o at the last read data until the next read completes; writes SHALL NOT change it.
REQ-022 If s_wb_stb_i falls mid-transaction (protocol violation), SHALL still complete the AXI transaction and pulse ack.
REQ-023 SHALL ignore s_wb_stb_i in every state other than IDLE.

Reset
REQ-024 While aresetn=0, SHALL asynchronously hold:
- state = IDLE
- all *valid, bready, rready, s_wb_ack_o, s_wb_err_o = 0
- s_wb_dat_o = 0, awaddr/araddr/wdata/wstrb = 0
REQ-025 On reset assertion mid-transaction, SHALL drop all AXI valids and readies in the same cycle, abandon the transaction, and never issue an ack for it.
REQ-026 After aresetn rises, SHALL wait for the first sampled stb in IDLE before issuing any AXI valid.

Verification
REQ-027 Write, immediate slave: adr=0x10, dat=0xDEADBEEF, sel=0xF -> awaddr=0x40, wdata=0xDEADBEEF, wstrb=0xF, bresp=0 -> one ack at cycle 3, err=0.
REQ-028 Read with an rvalid delay of 5 cycles: adr=0x20, rdata=0x12345678 -> araddr=0x80; rready held for 6 cycles; ack with s_wb_dat_o=0x12345678.
REQ-029 Write with awready at cycle 4 and wready at cycle 2 -> wvalid falls after cycle 2, awvalid falls after cycle 4, bready rises only after both; bresp=2'b10 -> ack with err=1.
REQ-030 Back-to-back: stb held high across write then read -> second transaction's valid appears 2 cycles after the first ack; no duplicate transaction.
REQ-031 aresetn pulled low while in RDATA -> rready/ack go to 0 immediately; after release, a new read completes normally with no stale ack.
REQ-032 A random bench with randomized ready/valid delays SHALL check:
- AXI stability (REQ-012);
- one ack per stb transaction;
- a scoreboard against a memory model.

Source files
------------

// File: rtl/jelly_wishbone_to_axi4l.sv
// Wishbone classic slave to AXI4-Lite master bridge with a single transaction in flight.
// All AXI and Wishbone outputs are registered; ack is a one-cycle pulse from the ACK state.
module jelly_wishbone_to_axi4l #(
    parameter int  AXI4L_ADDR_WIDTH = 29,
    parameter int  AXI4L_DATA_SIZE  = 2,
    localparam int AXI4L_DATA_WIDTH = 8 << AXI4L_DATA_SIZE,
    localparam int AXI4L_STRB_WIDTH = 1 << AXI4L_DATA_SIZE,
    localparam int WB_ADR_WIDTH     = AXI4L_ADDR_WIDTH - AXI4L_DATA_SIZE,
    localparam int WB_DAT_WIDTH     = AXI4L_DATA_WIDTH,
    localparam int WB_SEL_WIDTH     = AXI4L_STRB_WIDTH
) (
    input  logic                          aclk,
    input  logic                          aresetn,

    input  logic [WB_ADR_WIDTH-1:0]       s_wb_adr_i,
    input  logic [WB_DAT_WIDTH-1:0]       s_wb_dat_i,
    output logic [WB_DAT_WIDTH-1:0]       s_wb_dat_o,
    input  logic                          s_wb_we_i,
    input  logic [WB_SEL_WIDTH-1:0]       s_wb_sel_i,
    input  logic                          s_wb_stb_i,
    output logic                          s_wb_ack_o,
    output logic                          s_wb_err_o,

    output logic [AXI4L_ADDR_WIDTH-1:0]   m_axi4l_awaddr,
    output logic [2:0]                    m_axi4l_awprot,
    output logic                          m_axi4l_awvalid,
    input  logic                          m_axi4l_awready,
    output logic [AXI4L_DATA_WIDTH-1:0]   m_axi4l_wdata,
    output logic [AXI4L_STRB_WIDTH-1:0]   m_axi4l_wstrb,
    output logic                          m_axi4l_wvalid,
    input  logic                          m_axi4l_wready,
    input  logic [1:0]                    m_axi4l_bresp,
    input  logic                          m_axi4l_bvalid,
    output logic                          m_axi4l_bready,
    output logic [AXI4L_ADDR_WIDTH-1:0]   m_axi4l_araddr,
    output logic [2:0]                    m_axi4l_arprot,
    output logic                          m_axi4l_arvalid,
    input  logic                          m_axi4l_arready,
    input  logic [AXI4L_DATA_WIDTH-1:0]   m_axi4l_rdata,
    input  logic [1:0]                    m_axi4l_rresp,
    input  logic                          m_axi4l_rvalid,
    output logic                          m_axi4l_rready
);

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA,
        ACK
    } state_t;

    state_t                        state;
    logic [AXI4L_ADDR_WIDTH-1:0]   addr;
    logic                          err;

    // Only one transaction is ever outstanding, so reads and writes share the address register.
    assign m_axi4l_awaddr = addr;
    assign m_axi4l_araddr = addr;
    assign m_axi4l_awprot = 3'b000;
    assign m_axi4l_arprot = 3'b000;
    assign s_wb_err_o     = err;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state           <= IDLE;
            addr            <= '0;
            m_axi4l_wdata   <= '0;
            m_axi4l_wstrb   <= '0;
            m_axi4l_awvalid <= 1'b0;
            m_axi4l_wvalid  <= 1'b0;
            m_axi4l_bready  <= 1'b0;
            m_axi4l_arvalid <= 1'b0;
            m_axi4l_rready  <= 1'b0;
            s_wb_ack_o      <= 1'b0;
            s_wb_dat_o      <= '0;
            err             <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_wb_stb_i) begin
                        addr          <= AXI4L_ADDR_WIDTH'(s_wb_adr_i) << AXI4L_DATA_SIZE;
                        m_axi4l_wdata <= s_wb_dat_i;
                        m_axi4l_wstrb <= s_wb_sel_i;
                        if (s_wb_we_i) begin
                            m_axi4l_awvalid <= 1'b1;
                            m_axi4l_wvalid  <= 1'b1;
                            state           <= WADDR;
                        end else begin
                            m_axi4l_arvalid <= 1'b1;
                            state           <= RADDR;
                        end
                    end
                end

                // Address and data channels complete independently, in any order.
                WADDR: begin
                    if (m_axi4l_awready) begin
                        m_axi4l_awvalid <= 1'b0;
                    end
                    if (m_axi4l_wready) begin
                        m_axi4l_wvalid <= 1'b0;
                    end
                    if ((!m_axi4l_awvalid || m_axi4l_awready) && (!m_axi4l_wvalid || m_axi4l_wready)) begin
                        m_axi4l_bready <= 1'b1;
                        state          <= WRESP;
                    end
                end

                WRESP: begin
                    if (m_axi4l_bvalid) begin
                        m_axi4l_bready <= 1'b0;
                        err            <= (m_axi4l_bresp != 2'b00);
                        s_wb_ack_o     <= 1'b1;
                        state          <= ACK;
                    end
                end

                RADDR: begin
                    if (m_axi4l_arready) begin
                        m_axi4l_arvalid <= 1'b0;
                        m_axi4l_rready  <= 1'b1;
                        state           <= RDATA;
                    end
                end

                RDATA: begin
                    if (m_axi4l_rvalid) begin
                        m_axi4l_rready <= 1'b0;
                        s_wb_dat_o     <= m_axi4l_rdata;
                        err            <= (m_axi4l_rresp != 2'b00);
                        s_wb_ack_o     <= 1'b1;
                        state          <= ACK;
                    end
                end

                // Strobe is deliberately not sampled here; a held strobe restarts from IDLE.
                ACK: begin
                    s_wb_ack_o <= 1'b0;
                    err        <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jelly_wishbone_to_axi4l.sv
// Bench for the Wishbone-to-AXI4-Lite bridge: a delay-programmable AXI-Lite slave with its own
// memory, a directed vector table, hand-written corner sequences and a randomized scoreboard run.
module tb_jelly_wishbone_to_axi4l;

    localparam int AW  = 29;
    localparam int DS  = 2;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int WAW = 27;

    logic            aclk;
    logic            aresetn;
    logic [WAW-1:0]  s_wb_adr_i;
    logic [DW-1:0]   s_wb_dat_i;
    logic [DW-1:0]   s_wb_dat_o;
    logic            s_wb_we_i;
    logic [SW-1:0]   s_wb_sel_i;
    logic            s_wb_stb_i;
    logic            s_wb_ack_o;
    logic            s_wb_err_o;
    logic [AW-1:0]   m_axi4l_awaddr;
    logic [2:0]      m_axi4l_awprot;
    logic            m_axi4l_awvalid;
    logic            m_axi4l_awready;
    logic [DW-1:0]   m_axi4l_wdata;
    logic [SW-1:0]   m_axi4l_wstrb;
    logic            m_axi4l_wvalid;
    logic            m_axi4l_wready;
    logic [1:0]      m_axi4l_bresp;
    logic            m_axi4l_bvalid;
    logic            m_axi4l_bready;
    logic [AW-1:0]   m_axi4l_araddr;
    logic [2:0]      m_axi4l_arprot;
    logic            m_axi4l_arvalid;
    logic            m_axi4l_arready;
    logic [DW-1:0]   m_axi4l_rdata;
    logic [1:0]      m_axi4l_rresp;
    logic            m_axi4l_rvalid;
    logic            m_axi4l_rready;

    jelly_wishbone_to_axi4l #(
        .AXI4L_ADDR_WIDTH (AW),
        .AXI4L_DATA_SIZE  (DS)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .s_wb_adr_i      (s_wb_adr_i),
        .s_wb_dat_i      (s_wb_dat_i),
        .s_wb_dat_o      (s_wb_dat_o),
        .s_wb_we_i       (s_wb_we_i),
        .s_wb_sel_i      (s_wb_sel_i),
        .s_wb_stb_i      (s_wb_stb_i),
        .s_wb_ack_o      (s_wb_ack_o),
        .s_wb_err_o      (s_wb_err_o),
        .m_axi4l_awaddr  (m_axi4l_awaddr),
        .m_axi4l_awprot  (m_axi4l_awprot),
        .m_axi4l_awvalid (m_axi4l_awvalid),
        .m_axi4l_awready (m_axi4l_awready),
        .m_axi4l_wdata   (m_axi4l_wdata),
        .m_axi4l_wstrb   (m_axi4l_wstrb),
        .m_axi4l_wvalid  (m_axi4l_wvalid),
        .m_axi4l_wready  (m_axi4l_wready),
        .m_axi4l_bresp   (m_axi4l_bresp),
        .m_axi4l_bvalid  (m_axi4l_bvalid),
        .m_axi4l_bready  (m_axi4l_bready),
        .m_axi4l_araddr  (m_axi4l_araddr),
        .m_axi4l_arprot  (m_axi4l_arprot),
        .m_axi4l_arvalid (m_axi4l_arvalid),
        .m_axi4l_arready (m_axi4l_arready),
        .m_axi4l_rdata   (m_axi4l_rdata),
        .m_axi4l_rresp   (m_axi4l_rresp),
        .m_axi4l_rvalid  (m_axi4l_rvalid),
        .m_axi4l_rready  (m_axi4l_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    // Slave behaviour knobs, set by the master side before each transaction.
    int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;

    logic [31:0] slave_mem [logic [28:0]];
    logic [31:0] ref_mem   [logic [26:0]];
    logic [28:0] last_awaddr, last_araddr;
    logic [31:0] last_wdata;
    logic [3:0]  last_wstrb;
    int          aw_hs = 0, ar_hs = 0, ack_count = 0;
    logic [31:0] last_rd = '0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // AXI-Lite slave: decisions are taken on the falling edge so every ready/valid it drives is
    // sampled cleanly by the DUT on the next rising edge.
    initial begin : slave
        bit          aw_got, w_got, b_pending, b_fire, b_err, r_pending, r_fire, r_err;
        int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        logic [28:0] aw_addr_got, r_addr;
        logic [31:0] w_data_got, word;
        logic [3:0]  w_strb_got;
        bit          p_awvalid, p_awready, p_wvalid, p_wready, p_arvalid, p_arready;
        logic [28:0] p_awaddr, p_araddr;
        logic [35:0] p_wpay;
        m_axi4l_awready = 0; m_axi4l_wready = 0; m_axi4l_arready = 0;
        m_axi4l_bvalid = 0; m_axi4l_bresp = 0;
        m_axi4l_rvalid = 0; m_axi4l_rresp = 0; m_axi4l_rdata = '0;
        aw_got = 0; w_got = 0; b_pending = 0; b_fire = 0; b_err = 0;
        r_pending = 0; r_fire = 0; r_err = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_addr_got = '0; r_addr = '0; w_data_got = '0; w_strb_got = '0; word = '0;
        p_awvalid = 0; p_awready = 0; p_wvalid = 0; p_wready = 0; p_arvalid = 0; p_arready = 0;
        p_awaddr = '0; p_araddr = '0; p_wpay = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                m_axi4l_awready = 0; m_axi4l_wready = 0; m_axi4l_arready = 0;
                m_axi4l_bvalid = 0; m_axi4l_bresp = 0;
                m_axi4l_rvalid = 0; m_axi4l_rresp = 0; m_axi4l_rdata = '0;
                aw_got = 0; w_got = 0; b_pending = 0; b_fire = 0; r_pending = 0; r_fire = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                p_awvalid = 0; p_wvalid = 0; p_arvalid = 0;
            end else begin
                if (s_wb_ack_o) ack_count++;
                if (s_wb_err_o) checkOutput("err_only_with_ack", s_wb_ack_o, 1);
                if (p_awvalid && !p_awready)
                    checkOutput("aw_stable", {m_axi4l_awvalid, m_axi4l_awaddr}, {1'b1, p_awaddr});
                if (p_wvalid && !p_wready)
                    checkOutput("w_stable", {m_axi4l_wvalid, m_axi4l_wstrb, m_axi4l_wdata}, {1'b1, p_wpay});
                if (p_arvalid && !p_arready)
                    checkOutput("ar_stable", {m_axi4l_arvalid, m_axi4l_araddr}, {1'b1, p_araddr});

                if (b_fire) begin m_axi4l_bvalid = 0; m_axi4l_bresp = 0; b_fire = 0; end
                if (b_pending) begin
                    if (b_cnt >= b_delay) begin
                        m_axi4l_bvalid = 1;
                        m_axi4l_bresp  = b_err ? 2'b10 : 2'b00;
                        if (m_axi4l_bready) begin b_fire = 1; b_pending = 0; end
                    end else b_cnt++;
                end

                if (r_fire) begin m_axi4l_rvalid = 0; m_axi4l_rresp = 0; m_axi4l_rdata = '0; r_fire = 0; end
                if (r_pending) begin
                    if (r_cnt >= r_delay) begin
                        r_err          = (r_addr >> 2) >= 29'h100;
                        m_axi4l_rvalid = 1;
                        m_axi4l_rresp  = r_err ? 2'b10 : 2'b00;
                        m_axi4l_rdata  = r_err ? 32'hBAD0_BAD0 :
                                         (slave_mem.exists(r_addr) ? slave_mem[r_addr] : 32'h0);
                        if (m_axi4l_rready) begin r_fire = 1; r_pending = 0; end
                    end else r_cnt++;
                end

                if (m_axi4l_awvalid && !aw_got) begin
                    if (aw_cnt >= aw_delay) begin
                        m_axi4l_awready = 1; aw_got = 1; aw_cnt = 0;
                        aw_addr_got = m_axi4l_awaddr; last_awaddr = m_axi4l_awaddr; aw_hs++;
                    end else begin m_axi4l_awready = 0; aw_cnt++; end
                end else begin m_axi4l_awready = 0; aw_cnt = 0; end

                if (m_axi4l_wvalid && !w_got) begin
                    if (w_cnt >= w_delay) begin
                        m_axi4l_wready = 1; w_got = 1; w_cnt = 0;
                        w_data_got = m_axi4l_wdata; w_strb_got = m_axi4l_wstrb;
                        last_wdata = m_axi4l_wdata; last_wstrb = m_axi4l_wstrb;
                    end else begin m_axi4l_wready = 0; w_cnt++; end
                end else begin m_axi4l_wready = 0; w_cnt = 0; end

                if (aw_got && w_got) begin
                    aw_got = 0; w_got = 0;
                    b_err = (aw_addr_got >> 2) >= 29'h100;
                    if (!b_err) begin
                        word = slave_mem.exists(aw_addr_got) ? slave_mem[aw_addr_got] : 32'h0;
                        for (int b = 0; b < 4; b++)
                            if (w_strb_got[b]) word[8*b +: 8] = w_data_got[8*b +: 8];
                        slave_mem[aw_addr_got] = word;
                    end
                    b_pending = 1; b_cnt = 0;
                end

                if (m_axi4l_arvalid && !r_pending && !r_fire) begin
                    if (ar_cnt >= ar_delay) begin
                        m_axi4l_arready = 1; ar_cnt = 0;
                        r_addr = m_axi4l_araddr; last_araddr = m_axi4l_araddr; ar_hs++;
                        r_pending = 1; r_cnt = 0;
                    end else begin m_axi4l_arready = 0; ar_cnt++; end
                end else begin m_axi4l_arready = 0; ar_cnt = 0; end

                p_awvalid = m_axi4l_awvalid; p_awready = m_axi4l_awready; p_awaddr = m_axi4l_awaddr;
                p_wvalid  = m_axi4l_wvalid;  p_wready  = m_axi4l_wready;
                p_wpay    = {m_axi4l_wstrb, m_axi4l_wdata};
                p_arvalid = m_axi4l_arvalid; p_arready = m_axi4l_arready; p_araddr = m_axi4l_araddr;
            end
        end
    end

    // One Wishbone classic cycle; cycles counts falling edges from the strobe sample to ack.
    task automatic applyStimulus(input bit we, input logic [26:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel, output logic [31:0] rdat,
                                 output bit err, output int cycles);
        int snap;
        bit got;
        @(negedge aclk);
        s_wb_stb_i = 1; s_wb_we_i = we; s_wb_adr_i = adr; s_wb_dat_i = dat; s_wb_sel_i = sel;
        snap = ack_count;
        got = 0; cycles = 0; rdat = '0; err = 0;
        for (int c = 1; c <= 200 && !got; c++) begin
            @(negedge aclk);
            if (s_wb_ack_o) begin got = 1; cycles = c; rdat = s_wb_dat_o; err = s_wb_err_o; end
        end
        s_wb_stb_i = 0;
        if (!got) begin
            total++; bad++;
            $display("[TB] FAIL ack_timeout: got no ack, expected ack within 200 cycles");
        end else begin
            @(negedge aclk);
            checkOutput("ack_one_cycle", s_wb_ack_o, 0);
            #1;
            checkOutput("ack_per_txn", ack_count - snap, 1);
        end
    endtask

    typedef struct packed {
        bit          we;
        logic [26:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          aw_d, w_d, b_d, ar_d, r_d;
        bit          exp_err;
        logic [31:0] exp_rdata;
        int          exp_cycles;
        logic [28:0] exp_axi_addr;
    } vec_t;

    vec_t vecs [9];

    initial begin : main
        logic [31:0] rd, exp_rd, word;
        bit          er, exp_err, we;
        int          cy, exp_cy, ack_at, first_ack, ar_seen, second_ack, snap_ack, snap_aw, snap_ar;
        logic [26:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        awv [16];
        logic        wv  [16];
        logic        br  [16];

        aresetn = 0; s_wb_stb_i = 0; s_wb_we_i = 0; s_wb_adr_i = '0; s_wb_dat_i = '0; s_wb_sel_i = '0;
        slave_mem[29'h80] = 32'h1234_5678;
        for (int i = 0; i < 16; i++) begin awv[i] = 0; wv[i] = 0; br[i] = 0; end

        vecs[0] = '{we:1, adr:27'h10,  dat:32'hDEAD_BEEF, sel:4'hF, aw_d:0, w_d:0, b_d:0, ar_d:0, r_d:0,
                    exp_err:0, exp_rdata:32'h0, exp_cycles:3, exp_axi_addr:29'h40};
        vecs[1] = '{we:0, adr:27'h10,  dat:32'h0, sel:4'h0, aw_d:0, w_d:0, b_d:0, ar_d:0, r_d:0,
                    exp_err:0, exp_rdata:32'hDEAD_BEEF, exp_cycles:3, exp_axi_addr:29'h40};
        vecs[2] = '{we:1, adr:27'h10,  dat:32'h1111_2222, sel:4'h3, aw_d:1, w_d:2, b_d:1, ar_d:0, r_d:0,
                    exp_err:0, exp_rdata:32'h0, exp_cycles:6, exp_axi_addr:29'h40};
        vecs[3] = '{we:0, adr:27'h10,  dat:32'h0, sel:4'h0, aw_d:0, w_d:0, b_d:0, ar_d:2, r_d:1,
                    exp_err:0, exp_rdata:32'hDEAD_2222, exp_cycles:6, exp_axi_addr:29'h40};
        vecs[4] = '{we:0, adr:27'h20,  dat:32'h0, sel:4'h0, aw_d:0, w_d:0, b_d:0, ar_d:0, r_d:5,
                    exp_err:0, exp_rdata:32'h1234_5678, exp_cycles:8, exp_axi_addr:29'h80};
        vecs[5] = '{we:1, adr:27'h100, dat:32'hCAFE_F00D, sel:4'hF, aw_d:3, w_d:1, b_d:0, ar_d:0, r_d:0,
                    exp_err:1, exp_rdata:32'h0, exp_cycles:6, exp_axi_addr:29'h400};
        vecs[6] = '{we:0, adr:27'h100, dat:32'h0, sel:4'h0, aw_d:0, w_d:0, b_d:0, ar_d:0, r_d:0,
                    exp_err:1, exp_rdata:32'hBAD0_BAD0, exp_cycles:3, exp_axi_addr:29'h400};
        vecs[7] = '{we:1, adr:27'h21,  dat:32'h0BAD_F00D, sel:4'h8, aw_d:0, w_d:3, b_d:2, ar_d:0, r_d:0,
                    exp_err:0, exp_rdata:32'h0, exp_cycles:8, exp_axi_addr:29'h84};
        vecs[8] = '{we:0, adr:27'h21,  dat:32'h0, sel:4'h0, aw_d:0, w_d:0, b_d:0, ar_d:0, r_d:0,
                    exp_err:0, exp_rdata:32'h0B00_0000, exp_cycles:3, exp_axi_addr:29'h84};

        // Reset values, then no AXI activity until a strobe arrives.
        repeat (3) @(negedge aclk);
        checkOutput("rst_valids", {m_axi4l_awvalid, m_axi4l_wvalid, m_axi4l_arvalid,
                                   m_axi4l_bready, m_axi4l_rready}, 5'b0);
        checkOutput("rst_ack_err", {s_wb_ack_o, s_wb_err_o}, 2'b0);
        checkOutput("rst_dat_o", s_wb_dat_o, 0);
        checkOutput("rst_payload", {m_axi4l_awaddr, m_axi4l_araddr, m_axi4l_wdata, m_axi4l_wstrb}, 0);
        checkOutput("prot", {m_axi4l_awprot, m_axi4l_arprot}, 6'b0);
        #2 aresetn = 1;
        repeat (5) @(negedge aclk);
        checkOutput("idle_no_valid", {m_axi4l_awvalid, m_axi4l_wvalid, m_axi4l_arvalid}, 3'b0);

        $display("[TB] directed vector table");
        for (int i = 0; i < 9; i++) begin
            aw_delay = vecs[i].aw_d; w_delay = vecs[i].w_d; b_delay = vecs[i].b_d;
            ar_delay = vecs[i].ar_d; r_delay = vecs[i].r_d;
            applyStimulus(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rd, er, cy);
            checkOutput($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
            checkOutput($sformatf("vec%0d_cycles", i), cy, vecs[i].exp_cycles);
            if (vecs[i].we) begin
                checkOutput($sformatf("vec%0d_awaddr", i), last_awaddr, vecs[i].exp_axi_addr);
                checkOutput($sformatf("vec%0d_wdata", i), {last_wstrb, last_wdata}, {vecs[i].sel, vecs[i].dat});
                checkOutput($sformatf("vec%0d_dat_hold", i), s_wb_dat_o, last_rd);
            end else begin
                checkOutput($sformatf("vec%0d_araddr", i), last_araddr, vecs[i].exp_axi_addr);
                checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
                last_rd = vecs[i].exp_rdata;
            end
        end

        $display("[TB] split write handshakes");
        aw_delay = 3; w_delay = 1; b_delay = 0;
        @(negedge aclk);
        s_wb_stb_i = 1; s_wb_we_i = 1; s_wb_adr_i = 27'h101; s_wb_dat_i = 32'h0123_4567; s_wb_sel_i = 4'hF;
        ack_at = 0; er = 0;
        for (int c = 1; c < 16 && ack_at == 0; c++) begin
            @(negedge aclk);
            awv[c] = m_axi4l_awvalid; wv[c] = m_axi4l_wvalid; br[c] = m_axi4l_bready;
            if (s_wb_ack_o) begin ack_at = c; er = s_wb_err_o; end
        end
        s_wb_stb_i = 0;
        checkOutput("split_wvalid", {wv[2], wv[3]}, 2'b10);
        checkOutput("split_awvalid", {awv[4], awv[5]}, 2'b10);
        checkOutput("split_bready", {br[4], br[5]}, 2'b01);
        checkOutput("split_ack_cycle", ack_at, 6);
        checkOutput("split_err", er, 1);
        @(negedge aclk);

        $display("[TB] back-to-back with strobe held");
        aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
        @(negedge aclk);
        snap_ack = ack_count; snap_aw = aw_hs; snap_ar = ar_hs;
        s_wb_stb_i = 1; s_wb_we_i = 1; s_wb_adr_i = 27'h60; s_wb_dat_i = 32'h5A5A_5A5A; s_wb_sel_i = 4'hF;
        first_ack = 0; ar_seen = 0; second_ack = 0;
        for (int c = 1; c < 40 && second_ack == 0; c++) begin
            @(negedge aclk);
            if (s_wb_ack_o && first_ack == 0) begin
                first_ack = c; s_wb_we_i = 0;
            end else if (s_wb_ack_o) begin
                second_ack = c; s_wb_stb_i = 0;
            end
            if (first_ack != 0 && ar_seen == 0 && m_axi4l_arvalid) ar_seen = c;
        end
        s_wb_stb_i = 0;
        checkOutput("b2b_first_ack", first_ack, 3);
        checkOutput("b2b_arvalid_gap", ar_seen - first_ack, 2);
        checkOutput("b2b_second_ack", second_ack, 7);
        checkOutput("b2b_rdata", s_wb_dat_o, 32'h5A5A_5A5A);
        last_rd = 32'h5A5A_5A5A;
        repeat (5) @(negedge aclk);
        #1;
        checkOutput("b2b_txn_counts", {8'(ack_count - snap_ack), 8'(aw_hs - snap_aw), 8'(ar_hs - snap_ar)},
                    {8'd2, 8'd1, 8'd1});

        $display("[TB] randomized scoreboard run");
        for (int n = 0; n < 80; n++) begin
            we  = 1'($urandom_range(0, 1));
            adr = ($urandom_range(0, 9) == 0) ? 27'(27'h100 + $urandom_range(0, 3))
                                              : 27'(27'h40 + $urandom_range(0, 31));
            dat = $urandom;
            sel = 4'($urandom_range(1, 15));
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 3);
            ar_delay = $urandom_range(0, 3); r_delay = $urandom_range(0, 3);
            exp_err = (adr >= 27'h100);
            if (we) exp_cy = 3 + ((aw_delay > w_delay) ? aw_delay : w_delay) + b_delay;
            else    exp_cy = 3 + ar_delay + r_delay;
            applyStimulus(we, adr, dat, sel, rd, er, cy);
            checkOutput("rnd_err", er, exp_err);
            checkOutput("rnd_cycles", cy, exp_cy);
            if (we) begin
                checkOutput("rnd_awaddr", last_awaddr, {adr, 2'b00});
                checkOutput("rnd_wpayload", {last_wstrb, last_wdata}, {sel, dat});
                checkOutput("rnd_dat_hold", s_wb_dat_o, last_rd);
                if (!exp_err) begin
                    word = ref_mem.exists(adr) ? ref_mem[adr] : 32'h0;
                    for (int b = 0; b < 4; b++) if (sel[b]) word[8*b +: 8] = dat[8*b +: 8];
                    ref_mem[adr] = word;
                end
            end else begin
                exp_rd = exp_err ? 32'hBAD0_BAD0 : (ref_mem.exists(adr) ? ref_mem[adr] : 32'h0);
                checkOutput("rnd_araddr", last_araddr, {adr, 2'b00});
                checkOutput("rnd_rdata", rd, exp_rd);
                last_rd = exp_rd;
            end
        end

        $display("[TB] reset during read data phase");
        ar_delay = 0; r_delay = 20;
        @(negedge aclk);
        snap_ack = ack_count; snap_ar = ar_hs;
        s_wb_stb_i = 1; s_wb_we_i = 0; s_wb_adr_i = 27'h20;
        repeat (4) @(negedge aclk);
        checkOutput("rst_mid_rready_before", m_axi4l_rready, 1);
        #2 aresetn = 0;
        #1;
        checkOutput("rst_mid_outputs", {m_axi4l_awvalid, m_axi4l_wvalid, m_axi4l_arvalid, m_axi4l_bready,
                                        m_axi4l_rready, s_wb_ack_o}, 6'b0);
        s_wb_stb_i = 0;
        repeat (3) @(negedge aclk);
        #2 aresetn = 1;
        repeat (30) @(negedge aclk);
        #1;
        checkOutput("rst_no_stale_ack", ack_count - snap_ack, 0);
        checkOutput("rst_no_new_ar", ar_hs - snap_ar, 1);
        checkOutput("rst_dat_cleared", s_wb_dat_o, 0);
        r_delay = 0;
        applyStimulus(1'b0, 27'h20, 32'h0, 4'h0, rd, er, cy);
        checkOutput("post_rst_rdata", rd, 32'h1234_5678);
        checkOutput("post_rst_cycles", cy, 3);
        checkOutput("post_rst_err", er, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
